// File: rtl/alu_mdu_if.sv
// Execute-stage bus for alu_mdu: ALU operands/results plus the MDU start/busy/done handshake.
// master drives operands and MDU control; slave is the execute unit.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       aluop;
    logic [WIDTH-1:0] porta;
    logic [WIDTH-1:0] portb;
    logic [WIDTH-1:0] outport;
    logic             ovf;
    logic             zero;
    logic             neg;
    logic             mdu_start;
    logic [1:0]       mduop;
    logic             mdu_abort;
    logic             mdu_busy;
    logic             mdu_done;
    logic             mdu_err;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output aluop, porta, portb, mdu_start, mduop, mdu_abort,
        input  outport, ovf, zero, neg, mdu_busy, mdu_done, mdu_err, hi, lo
    );

    modport slave (
        input  aluop, porta, portb, mdu_start, mduop, mdu_abort,
        output outport, ovf, zero, neg, mdu_busy, mdu_done, mdu_err, hi, lo
    );
endinterface

// File: rtl/alu_mdu.sv
// Execute unit: combinational ALU plus a radix-2 multiply/divide unit with HI/LO registers.
// Define ALU_MDU_DIV_EN to build the restoring divider; without it DIV/DIVU report an error.
//
// state | meaning
// IDLE  | waiting for mdu_start; HI/LO hold the last result
// RUN   | one shift-add / restoring-divide step per cycle, counter WIDTH..1
// FIX   | apply result signs and write HI/LO (or flag the error)
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_mdu_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_ADD  = 4'd8;
    localparam logic [3:0] OP_SUB  = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    logic [WIDTH-1:0] alu_res, alu_sum, alu_diff;
    logic             alu_ovf;

    always_comb begin
        alu_sum  = bus.porta + bus.portb;
        alu_diff = bus.porta - bus.portb;
        alu_res  = '0;
        alu_ovf  = 1'b0;
        case (bus.aluop)
            OP_AND:  alu_res = bus.porta & bus.portb;
            OP_OR:   alu_res = bus.porta | bus.portb;
            OP_XOR:  alu_res = bus.porta ^ bus.portb;
            OP_NOR:  alu_res = ~(bus.porta | bus.portb);
            OP_SLL:  alu_res = bus.portb << bus.porta[SHW-1:0];
            OP_SRL:  alu_res = bus.portb >> bus.porta[SHW-1:0];
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.porta) < $signed(bus.portb)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.porta < bus.portb};
            OP_ADD: begin
                alu_res = alu_sum;
                alu_ovf = (bus.porta[WIDTH-1] == bus.portb[WIDTH-1]) &&
                          (alu_sum[WIDTH-1] != bus.porta[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = alu_diff;
                alu_ovf = (bus.porta[WIDTH-1] != bus.portb[WIDTH-1]) &&
                          (alu_diff[WIDTH-1] != bus.porta[WIDTH-1]);
            end
            default: ;
        endcase
    end

    assign bus.outport = alu_res;
    assign bus.ovf     = alu_ovf;
    assign bus.zero    = (alu_res == '0);
    assign bus.neg     = alu_res[WIDTH-1];

    state_t             state_q, state_d;
    logic [SHW:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [1:0]         op_q, op_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               err_pend_q, err_pend_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               in_signed, in_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, prod;

    assign in_signed = ~bus.mduop[0];
    assign in_div    = bus.mduop[1];
    assign a_neg     = in_signed & bus.porta[WIDTH-1];
    assign b_neg     = in_signed & bus.portb[WIDTH-1];
    assign a_mag     = a_neg ? -bus.porta : bus.porta;
    assign b_mag     = b_neg ? -bus.portb : bus.portb;

    // acc = {partial product, remaining multiplier bits}; shifts right one bit per step
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign prod     = neg_lo_q ? -acc_q : acc_q;

`ifdef ALU_MDU_DIV_EN
    // acc = {partial remainder, dividend/quotient}; shifts left one bit per step
    logic [WIDTH:0]     rem_sh, trial;
    logic [2*WIDTH-1:0] div_next;

    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, opnd_q};
    assign div_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        op_d       = op_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        err_pend_d = err_pend_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.mdu_start && !bus.mdu_abort) begin
                    op_d     = bus.mduop;
                    err_d    = 1'b0;
                    cnt_d    = (SHW+1)'(WIDTH);
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = in_div ? a_neg : (a_neg ^ b_neg);
                    if (in_div) begin
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                        opnd_d = b_mag;
`ifdef ALU_MDU_DIV_EN
                        err_pend_d = (bus.portb == '0);
                        state_d    = (bus.portb == '0) ? S_FIX : S_RUN;
`else
                        err_pend_d = 1'b1;
                        state_d    = S_FIX;
`endif
                    end else begin
                        acc_d      = {{WIDTH{1'b0}}, b_mag};
                        opnd_d     = a_mag;
                        err_pend_d = 1'b0;
                        state_d    = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.mdu_abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - (SHW+1)'(1);
`ifdef ALU_MDU_DIV_EN
                    acc_d = op_q[1] ? div_next : mul_next;
`else
                    acc_d = mul_next;
`endif
                    if (cnt_q == (SHW+1)'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.mdu_abort) begin
                    done_d = 1'b1;
                    if (err_pend_q) begin
                        err_d = 1'b1;
                    end else if (op_q[1]) begin
                        lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            op_q       <= '0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            err_pend_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            op_q       <= op_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            err_pend_q <= err_pend_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.mdu_busy = (state_q != S_IDLE);
    assign bus.mdu_done = done_q;
    assign bus.mdu_err  = err_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed ALU vectors plus an MDU scoreboard checked by done-driven monitors.
module tb_alu_mdu;
`ifdef ALU_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

    logic clk, rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb32[$];
    exp_t sb16[$];
    logic [31:0] m_hi, m_lo;

    alu_mdu_if #(.WIDTH(32)) bus32();
    alu_mdu_if #(.WIDTH(16)) bus16();

    alu_mdu #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    alu_mdu #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus32.mdu_done) begin
            checks++;
            if (sb32.size() == 0) begin
                errors++;
                $display("FAIL mdu32_unexpected_done cyc=%0d hi=%h lo=%h", cyc, bus32.hi, bus32.lo);
            end else begin
                exp_t e;
                e = sb32.pop_front();
                if (bus32.hi !== e.hi || bus32.lo !== e.lo || bus32.mdu_err !== e.err || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL mdu32_result got hi=%h lo=%h err=%b cyc=%0d exp hi=%h lo=%h err=%b cyc=%0d",
                             bus32.hi, bus32.lo, bus32.mdu_err, cyc, e.hi, e.lo, e.err, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus16.mdu_done) begin
            checks++;
            if (sb16.size() == 0) begin
                errors++;
                $display("FAIL mdu16_unexpected_done cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = sb16.pop_front();
                if ({16'h0, bus16.hi} !== e.hi || {16'h0, bus16.lo} !== e.lo ||
                    bus16.mdu_err !== e.err || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL mdu16_result got hi=%h lo=%h err=%b cyc=%0d exp hi=%h lo=%h err=%b cyc=%0d",
                             bus16.hi, bus16.lo, bus16.mdu_err, cyc, e.hi[15:0], e.lo[15:0], e.err, e.cyc);
                end
            end
        end
    end

    // Issue one op on the 32-bit unit; optionally pulse a second (ignored) start at cycle restart_at.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic eerr,
                          input int lat, input bit chain, input int restart_at);
        int s;
        exp_t e;
        if (!chain) begin
            @(posedge clk);
            #1;
        end
        bus32.mdu_start = 1'b1;
        bus32.mduop     = op;
        bus32.porta     = a;
        bus32.portb     = b;
        s = cyc;
        e.hi = ehi; e.lo = elo; e.err = eerr; e.cyc = s + lat;
        sb32.push_back(e);
        m_hi = ehi;
        m_lo = elo;
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk);
            #1;
            bus32.mdu_start = 1'b0;
            if (c == restart_at) begin
                bus32.mdu_start = 1'b1;
                bus32.mduop     = MULT;
                bus32.porta     = 32'hFFFF_FFFF;
                bus32.portb     = 32'h0000_0009;
            end
            if (c == 1) begin
                chk("busy_first", {63'h0, bus32.mdu_busy}, 64'h1);
                chk("err_cleared", {63'h0, bus32.mdu_err}, 64'h0);
            end
            if (c == lat - 1) chk("busy_last", {63'h0, bus32.mdu_busy}, 64'h1);
            if (c == lat)     chk("busy_after", {63'h0, bus32.mdu_busy}, 64'h0);
        end
    endtask

    task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo);
        if (DIV_EN) run_op(op, a, b, ehi, elo, 1'b0, 34, 1'b0, 0);
        else        run_op(op, a, b, m_hi, m_lo, 1'b1, 2, 1'b0, 0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
    } alu_vec_t;

    alu_vec_t alu_vecs[13];

    initial begin
        int s;
        bit saw_done;
        exp_t e;

        alu_vecs[0]  = '{4'd8, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1};
        alu_vecs[1]  = '{4'd9, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0};
        alu_vecs[2]  = '{4'd0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0};
        alu_vecs[3]  = '{4'd1, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0};
        alu_vecs[4]  = '{4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0};
        alu_vecs[5]  = '{4'd3, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        alu_vecs[6]  = '{4'd4, 32'h0000_0004, 32'h0000_0001, 32'h0000_0010, 1'b0};
        alu_vecs[7]  = '{4'd5, 32'h0000_001F, 32'h8000_0000, 32'h0000_0001, 1'b0};
        alu_vecs[8]  = '{4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
        alu_vecs[9]  = '{4'd7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        alu_vecs[10] = '{4'd9, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
        alu_vecs[11] = '{4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        alu_vecs[12] = '{4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0};

        rst = 1'b1;
        bus32.aluop = 4'd0; bus32.porta = '0; bus32.portb = '0;
        bus32.mdu_start = 1'b0; bus32.mduop = 2'd0; bus32.mdu_abort = 1'b0;
        bus16.aluop = 4'd0; bus16.porta = '0; bus16.portb = '0;
        bus16.mdu_start = 1'b0; bus16.mduop = 2'd0; bus16.mdu_abort = 1'b0;
        m_hi = '0;
        m_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", {32'h0, bus32.hi}, 64'h0);
        chk("rst_lo", {32'h0, bus32.lo}, 64'h0);
        chk("rst_busy_done_err", {61'h0, bus32.mdu_busy, bus32.mdu_done, bus32.mdu_err}, 64'h0);
        rst = 1'b0;

        foreach (alu_vecs[i]) begin
            bus32.aluop = alu_vecs[i].op;
            bus32.porta = alu_vecs[i].a;
            bus32.portb = alu_vecs[i].b;
            #1;
            chk($sformatf("alu_out_%0d", i), {32'h0, bus32.outport}, {32'h0, alu_vecs[i].res});
            chk($sformatf("alu_flags_%0d", i), {61'h0, bus32.ovf, bus32.zero, bus32.neg},
                {61'h0, alu_vecs[i].ovf, alu_vecs[i].res == 32'h0, alu_vecs[i].res[31]});
        end

        run_op(MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 1'b0, 0);
        run_div(DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div(DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);
        run_div(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_div(DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_div(DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E);

        // preload HI/LO = 0x1111/0x2222, then divide by zero, then a start in the DONE cycle
        run_op(MULTU, 32'h0000_2222, 32'h8000_0001, 32'h0000_1111, 32'h0000_2222, 1'b0, 34, 1'b0, 0);
        run_op(DIV, 32'h0000_0005, 32'h0000_0000, 32'h0000_1111, 32'h0000_2222, 1'b1, 2, 1'b0, 0);
        run_op(MULT, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0, 34, 1'b1, 0);

        run_op(MULTU, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0000_001E, 1'b0, 34, 1'b0, 5);

        // abort mid-multiply, with an ignored second start at cycle 5
        @(posedge clk);
        #1;
        bus32.mdu_start = 1'b1; bus32.mduop = MULTU;
        bus32.porta = 32'hDEAD_BEEF; bus32.portb = 32'h0000_0003;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk);
            #1;
            bus32.mdu_start = (c == 5);
            bus32.mdu_abort = (c == 10);
        end
        chk("abort_busy", {63'h0, bus32.mdu_busy}, 64'h0);
        saw_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus32.mdu_done) saw_done = 1'b1;
        end
        chk("abort_no_done", {63'h0, saw_done}, 64'h0);
        chk("abort_hilo", {bus32.hi, bus32.lo}, {m_hi, m_lo});
        chk("abort_err", {63'h0, bus32.mdu_err}, 64'h0);

        // reset in the middle of a long op
        @(posedge clk);
        #1;
        bus32.mdu_start = 1'b1; bus32.mduop = DIV_EN ? DIVU : MULTU;
        bus32.porta = 32'h0000_0064; bus32.portb = 32'h0000_0007;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            bus32.mdu_start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_hilo", {bus32.hi, bus32.lo}, 64'h0);
        chk("midrst_flags", {61'h0, bus32.mdu_busy, bus32.mdu_done, bus32.mdu_err}, 64'h0);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        run_op(MULTU, 32'h0000_0010, 32'h0000_0010, 32'h0000_0000, 32'h0000_0100, 1'b0, 34, 1'b0, 0);

        // 16-bit instance: unsigned full-scale multiply
        @(posedge clk);
        #1;
        bus16.mdu_start = 1'b1; bus16.mduop = MULTU;
        bus16.porta = 16'hFFFF; bus16.portb = 16'hFFFF;
        s = cyc;
        e.hi = 32'h0000_FFFE; e.lo = 32'h0000_0001; e.err = 1'b0; e.cyc = s + 18;
        sb16.push_back(e);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            bus16.mdu_start = 1'b0;
            if (c == 17) chk("w16_busy_last", {63'h0, bus16.mdu_busy}, 64'h1);
        end

        repeat (3) @(posedge clk);
        chk("sb32_drained", 64'(sb32.size()), 64'h0);
        chk("sb16_drained", 64'(sb16.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
